// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: mask-driven ADC channel scanner with a 16-entry result bank,
// registered read port, optional periodic restart and per-conversion timeout.
module adc_scan_scheduler #(
  parameter int unsigned INTERVAL = 1000,
  parameter int unsigned TIMEOUT  = 4095
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Enable,
  input  logic        Start,
  input  logic [15:0] Channel_Mask,
  output logic        Read,
  output logic [3:0]  Channel_Select,
  input  logic [11:0] ADC_DATA,
  input  logic        ADC_STS,
  input  logic [3:0]  Rd_Addr,
  output logic [11:0] Rd_Data,
  output logic [15:0] Result_Valid,
  output logic        Busy,
  output logic        Scan_Done,
  output logic        Timeout_Err,
  input  logic        Err_Clr
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WAIT_HI, S_WAIT_LO, S_CAPTURE, S_NEXT, S_GAP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(INTERVAL - 1);

  state_t      r_state;
  logic [15:0] r_mask_q;
  logic [15:0] r_valid;
  logic [3:0]  r_ch;
  logic [15:0] r_tmo;
  logic [15:0] r_gap;
  logic        r_auto;
  logic        r_read;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [11:0] r_bank [16];
  logic [11:0] r_rd_data;

  logic [15:0] w_higher;
  logic        w_start;
  logic        w_tmo_hit;
  logic        w_bank_we;

  function automatic logic [3:0] f_lowest(input logic [15:0] m);
    f_lowest = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) f_lowest = 4'(i);
    end
  endfunction

  // NOTE: give w_higher a default before the loop so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_higher = '0;
    for (int i = 0; i < 16; i++) begin
      w_higher[i] = r_mask_q[i] && (4'(i) > r_ch);
    end
  end

  assign w_start   = Start || (r_auto && Enable);
  assign w_tmo_hit = (r_tmo >= TMO_LAST);
  assign w_bank_we = (r_state == S_CAPTURE);

  // NOTE: non-blocking assignments so every register in this block sees pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_mask_q <= '0;
      r_valid  <= '0;
      r_ch     <= '0;
      r_tmo    <= '0;
      r_gap    <= '0;
      r_auto   <= 1'b0;
      r_read   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A timeout later in this block overrides the clear, so a coincident set wins.
      if (Err_Clr) r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_auto <= 1'b0;
          if (w_start) begin
            r_mask_q <= Channel_Mask;
            if (Channel_Mask != '0) begin
              r_ch    <= f_lowest(Channel_Mask);
              r_busy  <= 1'b1;
              r_state <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          r_read  <= 1'b1;
          r_tmo   <= '0;
          r_state <= S_WAIT_HI;
        end
        S_WAIT_HI, S_WAIT_LO: begin
          r_tmo <= r_tmo + 16'd1;
          // A real ADC handshake takes precedence over a timeout expiring in the same cycle.
          if ((r_state == S_WAIT_HI) && ADC_STS) begin
            r_state <= S_WAIT_LO;
          end else if ((r_state == S_WAIT_LO) && !ADC_STS) begin
            r_state <= S_CAPTURE;
          end else if (w_tmo_hit) begin
            r_err         <= 1'b1;
            r_valid[r_ch] <= 1'b0;
            r_read        <= 1'b0;
            r_state       <= S_NEXT;
          end
        end
        S_CAPTURE: begin
          r_valid[r_ch] <= 1'b1;
          r_read        <= 1'b0;
          r_state       <= S_NEXT;
        end
        S_NEXT: begin
          if (w_higher != '0) begin
            r_ch    <= f_lowest(w_higher);
            r_state <= S_SELECT;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_gap   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (!Enable) begin
            r_state <= S_IDLE;
          end else if (r_gap == GAP_LAST) begin
            r_gap   <= '0;
            r_auto  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the bank is built from flops and is cleared on reset so it reads back 0 afterwards.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) r_bank[i] <= '0;
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_bank[Rd_Addr];
      if (w_bank_we) r_bank[r_ch] <= ADC_DATA;
    end
  end

  assign Read           = r_read;
  assign Channel_Select = r_ch;
  assign Rd_Data        = r_rd_data;
  assign Result_Valid   = r_valid;
  assign Busy           = r_busy;
  assign Scan_Done      = r_done;
  assign Timeout_Err    = r_err;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Scoreboard bench for adc_scan_scheduler: a behavioural ADC front-end answers requests,
// stimulus queues expected conversions and scan completions, a monitor pops and compares.
module tb_adc_scan_scheduler;

  localparam int INTERVAL = 10;
  localparam int TIMEOUT  = 20;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        start;
  logic [15:0] mask;
  logic        read_o;
  logic [3:0]  chsel;
  logic [11:0] adc_data;
  logic        adc_sts;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data;
  logic [15:0] valid;
  logic        busy;
  logic        done;
  logic        terr;
  logic        err_clr;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic [3:0]  ch;
    logic [11:0] data;
    bit          abort;
    bit          gap_chk;
  } conv_t;

  conv_t       q_conv [$];
  logic [15:0] q_done [$];
  logic [11:0] val [16];
  bit          stuck [16];
  logic [11:0] model_bank [16];

  adc_scan_scheduler #(.INTERVAL(INTERVAL), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RST(rst), .Enable(enable), .Start(start), .Channel_Mask(mask),
    .Read(read_o), .Channel_Select(chsel), .ADC_DATA(adc_data), .ADC_STS(adc_sts),
    .Rd_Addr(rd_addr), .Rd_Data(rd_data), .Result_Valid(valid), .Busy(busy),
    .Scan_Done(done), .Timeout_Err(terr), .Err_Clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_conv(input logic [3:0] ch, input logic [11:0] d, input bit ab, input bit g);
    conv_t e;
    e.ch = ch; e.data = d; e.abort = ab; e.gap_chk = g;
    q_conv.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int c = 0;
    while (done_cnt < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("scan_done_count", done_cnt, n);
  endtask

  // Behavioural front-end: rises ADC_STS two cycles after Read, holds it three cycles,
  // then drops it with the channel's value; a stuck channel never answers.
  initial begin : adc_model
    logic [3:0] mch;
    int n;
    adc_sts = 1'b0;
    adc_data = '0;
    forever begin
      @(posedge clk); #1;
      if (read_o && !rst) begin
        mch = chsel;
        if (!stuck[mch]) begin
          repeat (2) @(posedge clk);
          #1; adc_sts = 1'b1;
          repeat (3) @(posedge clk);
          #1; adc_sts = 1'b0;
          adc_data = val[mch];
          val[mch] = val[mch] + 12'd1;
        end
        n = 0;
        while (read_o && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
      end
    end
  end

  initial begin : monitor
    bit prev_read, prev_busy, in_conv, pend;
    logic [11:0] pend_val;
    int high_cnt, since_done;
    conv_t cur;
    prev_read = 0; prev_busy = 0; in_conv = 0; pend = 0;
    pend_val = '0; high_cnt = 0; since_done = 0;
    rd_addr = '0;
    forever begin
      @(negedge clk);
      since_done++;
      if (rst) begin
        prev_read = 0; prev_busy = 0; in_conv = 0; pend = 0;
      end else begin
        if (pend) begin
          check("rd_new", rd_data, pend_val);
          pend = 0;
        end
        if (read_o && !prev_read) begin
          check("read_expected", q_conv.size() != 0, 1);
          if (q_conv.size() != 0) begin
            cur = q_conv.pop_front();
            check("conv_channel", chsel, cur.ch);
            if (cur.gap_chk) check("gap_edges", since_done, INTERVAL + 2);
            rd_addr = chsel;
            high_cnt = 1;
            in_conv = 1;
          end
        end else if (read_o) begin
          high_cnt++;
        end
        if (!read_o && prev_read && in_conv) begin
          check("valid_bit", valid[cur.ch], !cur.abort);
          check("rd_old", rd_data, model_bank[cur.ch]);
          if (cur.abort) check("timeout_len", high_cnt, TIMEOUT);
          pend_val = cur.abort ? model_bank[cur.ch] : cur.data;
          model_bank[cur.ch] = pend_val;
          pend = 1;
          in_conv = 0;
        end
        if (done) begin
          check("done_expected", q_done.size() != 0, 1);
          if (q_done.size() != 0) check("done_valid", valid, q_done.pop_front());
          check("busy_at_done", busy, 0);
          done_cnt++;
          since_done = 0;
        end
        if (!busy && prev_busy) check("busy_continuous", done, 1);
        prev_read = read_o;
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int c;
    rst = 1'b1; enable = 1'b0; start = 1'b0; mask = '0; err_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      val[i] = '0; stuck[i] = 0; model_bank[i] = '0;
    end
    #1;
    check("rst_read", read_o, 0);
    check("rst_chsel", chsel, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_terr", terr, 0);
    check("rst_rd_data", rd_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single channel, with start-to-request latency.
    mask = 16'h0004; val[2] = 12'd5;
    push_conv(4'd2, 12'd5, 0, 0); q_done.push_back(16'h0004);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("read_edge0", read_o, 0);
    check("busy_edge0", busy, 1);
    @(negedge clk);
    check("read_edge1", read_o, 1);
    check("chsel_edge1", chsel, 2);
    wait_done(1);

    // Multi-channel ascending order; a Start with a new mask mid-scan is ignored.
    mask = 16'h8011; val[0] = 12'd100; val[4] = 12'd104; val[15] = 12'd115;
    push_conv(4'd0, 12'd100, 0, 0);
    push_conv(4'd4, 12'd104, 0, 0);
    push_conv(4'd15, 12'd115, 0, 0);
    q_done.push_back(16'h8015);
    pulse_start();
    repeat (4) @(negedge clk);
    check("busy_mid_scan", busy, 1);
    mask = 16'h0002;
    pulse_start();
    mask = 16'h8011;
    wait_done(2);
    repeat (5) @(negedge clk);

    // Empty mask: no request, no completion.
    mask = 16'h0000;
    pulse_start();
    repeat (8) @(negedge clk);
    check("mask0_read", read_o, 0);
    check("mask0_busy", busy, 0);
    check("mask0_done_cnt", done_cnt, 2);

    // Reconvert channel 2: same-address read during capture sees the old 5.
    mask = 16'h0004; val[2] = 12'd77;
    push_conv(4'd2, 12'd77, 0, 0); q_done.push_back(16'h8015);
    pulse_start();
    wait_done(3);

    // Timeout on channel 0, channel 1 converts normally, then clear the flag.
    mask = 16'h0003; stuck[0] = 1; val[1] = 12'd11;
    push_conv(4'd0, 12'd0, 1, 0);
    push_conv(4'd1, 12'd11, 0, 0);
    q_done.push_back(16'h8016);
    pulse_start();
    wait_done(4);
    check("terr_set", terr, 1);
    stuck[0] = 0;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    check("terr_cleared", terr, 0);

    // Periodic scanning; drop Enable during the third scan.
    enable = 1'b1; mask = 16'h0002; val[1] = 12'd21;
    push_conv(4'd1, 12'd21, 0, 0); q_done.push_back(16'h8016);
    push_conv(4'd1, 12'd22, 0, 1); q_done.push_back(16'h8016);
    push_conv(4'd1, 12'd23, 0, 1); q_done.push_back(16'h8016);
    pulse_start();
    wait_done(6);
    c = 0;
    while (!read_o && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("third_scan_started", read_o, 1);
    enable = 1'b0;
    wait_done(7);
    repeat (40) @(negedge clk);
    check("no_restart_read", read_o, 0);
    check("no_restart_busy", busy, 0);
    check("no_restart_done_cnt", done_cnt, 7);

    // Reset while waiting for the conversion to finish.
    mask = 16'h0010;
    push_conv(4'd4, 12'd0, 0, 0);
    pulse_start();
    c = 0;
    while (!adc_sts && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("sts_seen", adc_sts, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_read", read_o, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", valid, 0);
    for (int i = 0; i < 16; i++) model_bank[i] = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("bank_cleared", rd_data, 0);
    repeat (6) @(negedge clk);
    val[4] = 12'd44;
    push_conv(4'd4, 12'd44, 0, 0); q_done.push_back(16'h0010);
    pulse_start();
    wait_done(8);
    repeat (4) @(negedge clk);

    check("conv_queue_empty", q_conv.size(), 0);
    check("done_queue_empty", q_done.size(), 0);
    check("terr_final", terr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
